mem_arbiter: RTL and testbench

//  Shares the single memory port between two requesters: the CPU (fetch/load/store) and a

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency memory port.
// CPU and host requests are latched at grant, run for MEM_LATENCY strobe cycles, then acked.
module mem_arbiter #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 16,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [MEM_ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]     cpu_wdata,
    output logic                     cpu_ack,
    output logic [WORD_SIZE-1:0]     cpu_rdata,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [MEM_ADDR_SIZE-1:0] host_addr,
    input  logic [WORD_SIZE-1:0]     host_wdata,
    input  logic                     host_lock,
    output logic                     host_ack,
    output logic [WORD_SIZE-1:0]     host_rdata,
    output logic [MEM_ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]     mem_write_data,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [WORD_SIZE-1:0]     mem_read_data,
    output logic [1:0]               grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       owner_host_q, owner_host_d;
    logic                       last_host_q, last_host_d;
    logic                       lock_q, lock_d;
    logic                       we_q, we_d;
    logic [MEM_ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]       wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic [WORD_SIZE-1:0]       host_rdata_q, host_rdata_d;
    logic                       pick_host;

    // Host wins when alone, when the CPU was served last, or when its locked burst continues.
    assign pick_host = host_req && (!cpu_req || !last_host_q || lock_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_host_q <= 1'b0;
            last_host_q  <= 1'b1;
            lock_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_host_q <= owner_host_d;
            last_host_q  <= last_host_d;
            lock_q       <= lock_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cpu_req || host_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        cnt_d        = cnt_q;
        owner_host_d = owner_host_q;
        last_host_d  = last_host_q;
        lock_d       = lock_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || host_req) begin
                    owner_host_d = pick_host;
                    last_host_d  = pick_host;
                    we_d         = pick_host ? host_we    : cpu_we;
                    addr_d       = pick_host ? host_addr  : cpu_addr;
                    wdata_d      = pick_host ? host_wdata : cpu_wdata;
                    cnt_d        = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!we_q) begin
                    if (owner_host_q) host_rdata_d = mem_read_data;
                    else              cpu_rdata_d  = mem_read_data;
                end
            end
            RESP: begin
                if (owner_host_q) lock_d = host_lock;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        cpu_ack        = 1'b0;
        host_ack       = 1'b0;
        grant          = 2'b00;
        unique case (state_q)
            ACCESS: begin
                mem_read    = ~we_q;
                mem_write   = we_q;
                mem_address = addr_q;
                if (we_q) mem_write_data = wdata_q;
                grant       = owner_host_q ? 2'b10 : 2'b01;
            end
            RESP: begin
                cpu_ack  = ~owner_host_q;
                host_ack = owner_host_q;
                grant    = owner_host_q ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-timeline reference model through a scoreboard queue.
module tb_mem_arbiter;

    localparam int W = 16;
    localparam int A = 16;
    localparam int L = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_we, cpu_ack;
    logic [A-1:0] cpu_addr;
    logic [W-1:0] cpu_wdata, cpu_rdata;
    logic         host_req, host_we, host_lock, host_ack;
    logic [A-1:0] host_addr;
    logic [W-1:0] host_wdata, host_rdata;
    logic [A-1:0] mem_address;
    logic [W-1:0] mem_write_data, mem_read_data;
    logic         mem_read, mem_write;
    logic [1:0]   grant;

    mem_arbiter #(.WORD_SIZE(W), .MEM_ADDR_SIZE(A), .MEM_LATENCY(L)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
        .grant(grant)
    );

    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    function automatic logic [W-1:0] init_val(input int i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // Memory behind the arbiter: combinational read, write on each strobed edge.
    logic [W-1:0] mem [0:255];
    bit           mem_init = 1'b0;
    assign mem_read_data = mem[mem_address[7:0]];
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address[7:0]] <= mem_write_data;
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
        end
    endtask

    // Reference model: arbitration decisions on a timeline of edge numbers.
    typedef struct {
        bit           host;
        bit           we;
        logic [A-1:0] addr;
        logic [W-1:0] wdata;
        int           grant_edge;
        int           ack_edge;
        logic [W-1:0] exp_cpu_rd;
        logic [W-1:0] exp_host_rd;
    } txn_t;

    txn_t         sb[$];
    logic [W-1:0] shadow [0:255];
    int           free_at   = 0;
    bit           last_host = 1'b1;
    bit           lock      = 1'b0;
    int           lock_edge = -1;
    logic [W-1:0] exp_rd_cpu  = '0;
    logic [W-1:0] exp_rd_host = '0;

    task automatic model_step();
        int e;
        e = edge_n;
        if (!reset) begin
            while (sb.size() > 0 && sb[$].ack_edge >= e) void'(sb.pop_back());
            free_at     = e + 1;
            last_host   = 1'b1;
            lock        = 1'b0;
            lock_edge   = -1;
            exp_rd_cpu  = '0;
            exp_rd_host = '0;
            return;
        end
        if (e == lock_edge) lock = host_lock;
        if (e >= free_at && (cpu_req || host_req)) begin
            txn_t t;
            bit   h;
            if (cpu_req && host_req) h = !last_host || lock;
            else                     h = host_req;
            t.host       = h;
            t.we         = h ? host_we    : cpu_we;
            t.addr       = h ? host_addr  : cpu_addr;
            t.wdata      = h ? host_wdata : cpu_wdata;
            t.grant_edge = e;
            t.ack_edge   = e + L;
            if (t.we)   shadow[t.addr[7:0]] = t.wdata;
            else if (h) exp_rd_host = shadow[t.addr[7:0]];
            else        exp_rd_cpu  = shadow[t.addr[7:0]];
            t.exp_cpu_rd  = exp_rd_cpu;
            t.exp_host_rd = exp_rd_host;
            sb.push_back(t);
            free_at   = e + L + 2;
            lock_edge = h ? e + L + 1 : -1;
            last_host = h;
        end
    endtask

    // Monitor: compares DUT outputs against the head of the scoreboard every cycle.
    task automatic monitor_cycle();
        txn_t       cur;
        bit         in_acc  = 1'b0;
        bit         in_resp = 1'b0;
        logic [5:0] exp_ctrl;
        if (sb.size() > 0 && sb[0].ack_edge < edge_n) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_ack: txn due at edge %0d not completed, now edge %0d",
                     sb[0].ack_edge, edge_n);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].grant_edge <= edge_n) begin
            cur     = sb[0];
            in_acc  = edge_n < cur.ack_edge;
            in_resp = !in_acc;
        end
        exp_ctrl = {(in_acc || in_resp) ? (cur.host ? 2'b10 : 2'b01) : 2'b00,
                    in_acc && !cur.we, in_acc && cur.we,
                    in_resp && !cur.host, in_resp && cur.host};
        check("grant/strobes/acks", 64'({grant, mem_read, mem_write, cpu_ack, host_ack}),
              64'(exp_ctrl));
        check("mem_address", 64'(mem_address), in_acc ? 64'(cur.addr) : 64'(0));
        check("mem_write_data", 64'(mem_write_data),
              (in_acc && cur.we) ? 64'(cur.wdata) : 64'(0));
        if (in_resp) begin
            check("cpu_rdata/host_rdata", 64'({cpu_rdata, host_rdata}),
                  64'({cur.exp_cpu_rd, cur.exp_host_rd}));
            void'(sb.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            monitor_cycle();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic wait_ack(input bit host, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (host ? host_ack : cpu_ack) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL ack_timeout: no %s ack within %0d cycles", host ? "host" : "cpu", budget);
    endtask

    task automatic wait_any_ack(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (cpu_ack || host_ack) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL ack_timeout: no ack within %0d cycles", budget);
    endtask

    task automatic rand_cpu();
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 63));
        cpu_wdata = 16'($urandom);
    endtask

    task automatic rand_host();
        host_req   = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 16'($urandom_range(0, 63));
        host_wdata = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_lock = 1'b0;

        // Reset held with a pending CPU read of 0x0010, then normal completion.
        repeat (3) step();
        reset = 1'b1;
        wait_ack(1'b0, 10);
        cpu_req = 1'b0;
        repeat (2) step();

        // Both requesters held high after reset: CPU, host, CPU, host.
        reset = 1'b0;
        step();
        reset = 1'b1;
        cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 16'h0005;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0006;
        for (int k = 0; k < 4; k++) wait_any_ack(20);
        cpu_req = 1'b0; host_req = 1'b0;
        repeat (2) step();

        // Locked host burst of four writes while the CPU waits.
        reset = 1'b0;
        step();
        reset = 1'b1;
        host_lock = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0000; host_wdata = 16'h00A0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1'b1, 20);
            if (k < 3) begin
                host_addr  = 16'(k + 1);
                host_wdata = 16'(16'h00A1 + k);
            end else begin
                host_lock = 1'b0;
                host_req  = 1'b0;
            end
        end
        wait_ack(1'b0, 20);
        cpu_req = 1'b0;
        repeat (2) step();

        // Reset in the first ACCESS cycle of a CPU read; the held request then completes.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        wait_ack(1'b0, 10);
        cpu_req = 1'b0;
        repeat (2) step();

        // Host write then CPU read of the same word; host_rdata must hold.
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 16'h1234;
        wait_ack(1'b1, 10);
        host_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        wait_ack(1'b0, 10);
        cpu_req = 1'b0;
        repeat (2) step();

        // Random traffic: payload changes, dropped requests, back-to-back requests, random lock.
        for (int i = 0; i < 1500; i++) begin
            step();
            host_lock = 1'($urandom_range(0, 1));
            if (cpu_ack) begin
                if ($urandom_range(0, 1) == 1) rand_cpu();
                else cpu_req = 1'b0;
            end else if (!cpu_req) begin
                if ($urandom_range(0, 3) == 0) rand_cpu();
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                rand_cpu();
            end
            if (host_ack) begin
                if ($urandom_range(0, 1) == 1) rand_host();
                else host_req = 1'b0;
            end else if (!host_req) begin
                if ($urandom_range(0, 3) == 0) rand_host();
            end else if ($urandom_range(0, 15) == 0) begin
                host_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                rand_host();
            end
        end

        cpu_req = 1'b0; host_req = 1'b0;
        repeat (10) step();
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
